// File: rtl/core2_wb_pkg.sv
// core2_wb_pkg: destination codes, opcode field positions and FSM encoding for core2_writeback.
package core2_wb_pkg;
    localparam logic [2:0] DEST_NONE = 3'b000;
    localparam logic [2:0] DEST_D    = 3'b100;
    localparam logic [2:0] DEST_FIFO = 3'b110;
    localparam int DEST_MSB = 8;
    localparam int DEST_LSB = 6;
    localparam int ADDR_MSB = 2;
    localparam int ADDR_LSB = 1;
    typedef enum logic [1:0] {IDLE, LATCH, COMMIT} state_t;
endpackage

// File: rtl/core2_wb_stat.sv
// core2_wb_stat: saturating commit counter and sticky bad-destination flag.
module core2_wb_stat (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w_D,
    input  logic       tmp_wr_en,
    input  logic       bad_dest,
    output logic [7:0] wb_count,
    output logic       err_sticky
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count   <= '0;
            err_sticky <= 1'b0;
        end else begin
            wb_count   <= ((w_D || tmp_wr_en) && wb_count != 8'hFF) ? wb_count + 8'd1 : wb_count;
            err_sticky <= err_sticky | bad_dest;
        end
    end
endmodule

// File: rtl/core2_writeback.sv
// core2_writeback: pairs Core2 results with delayed opcodes and commits them to RAM D or the temp FIFO.
// Optional CORE2_WB_STAT_EN adds wb_count / err_sticky statistics outputs.
module core2_writeback
    import core2_wb_pkg::*;
#(
    parameter int DATA        = 256,
    parameter int ADDR        = 2,
    parameter int OPCODE_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   res_rd_en,
    input  logic [DATA-1:0]        res_data,
    input  logic                   res_empty,
    output logic                   op_rd_en,
    input  logic [OPCODE_SIZE-1:0] op_data,
    input  logic                   op_empty,
    output logic                   w_D,
    output logic [ADDR-1:0]        adbus_D,
    output logic [DATA-1:0]        data_out_D,
    output logic                   tmp_wr_en,
    output logic [DATA-1:0]        tmp_data,
    input  logic                   tmp_full,
`ifdef CORE2_WB_STAT_EN
    output logic [7:0]             wb_count,
    output logic                   err_sticky,
`endif
    output logic                   bad_dest,
    output logic                   busy
);
    state_t                 state;
    logic [DATA-1:0]        hold_data;
    logic [OPCODE_SIZE-1:0] hold_op;
    logic [ADDR-1:0]        addr_q;
    logic [DATA-1:0]        d_q;
    logic [DATA-1:0]        t_q;
    logic [2:0]             dest;
    logic                   commit;
    logic                   pop;
    logic                   stall;
    logic                   unused_op;

    assign dest      = hold_op[DEST_MSB:DEST_LSB];
    assign commit    = state == COMMIT;
    assign pop       = rst_n && state == IDLE && !res_empty && !op_empty;
    assign stall     = commit && dest == DEST_FIFO && tmp_full;
    assign res_rd_en = pop;
    assign op_rd_en  = pop;
    assign w_D       = commit && dest == DEST_D;
    assign tmp_wr_en = commit && dest == DEST_FIFO && !tmp_full;
    assign bad_dest  = commit && dest != DEST_D && dest != DEST_FIFO && dest != DEST_NONE;
    assign busy      = state != IDLE;
    // Buses show the live value during the strobe and the last written value otherwise.
    assign adbus_D    = w_D ? hold_op[ADDR_MSB:ADDR_LSB] : addr_q;
    assign data_out_D = w_D ? hold_data : d_q;
    assign tmp_data   = tmp_wr_en ? hold_data : t_q;
    assign unused_op  = ^{hold_op[OPCODE_SIZE-1:DEST_MSB+1], hold_op[DEST_LSB-1:ADDR_MSB+1], hold_op[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_op   <= '0;
            addr_q    <= '0;
            d_q       <= '0;
            t_q       <= '0;
        end else begin
            state <= state == IDLE ? (pop ? LATCH : IDLE) : state == LATCH ? COMMIT : stall ? COMMIT : IDLE;
            if (state == LATCH) begin
                hold_data <= res_data;
                hold_op   <= op_data;
            end
            if (w_D) begin
                addr_q <= hold_op[ADDR_MSB:ADDR_LSB];
                d_q    <= hold_data;
            end
            if (tmp_wr_en) t_q <= hold_data;
        end
    end

`ifdef CORE2_WB_STAT_EN
    core2_wb_stat u_stat (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_D        (w_D),
        .tmp_wr_en  (tmp_wr_en),
        .bad_dest   (bad_dest),
        .wb_count   (wb_count),
        .err_sticky (err_sticky)
    );
`endif
endmodule

// File: tb/tb_core2_writeback.sv
// tb_core2_writeback: table-driven and scoreboard checks of core2_writeback; honours CORE2_WB_STAT_EN.
module tb_core2_writeback;
    import core2_wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest, busy;
    logic [255:0] res_data = '0;
    logic [15:0]  op_data = '0;
    logic         res_empty, op_empty;
    logic         tmp_full = 1'b0;
    logic [1:0]   adbus_D;
    logic [255:0] data_out_D, tmp_data;
`ifdef CORE2_WB_STAT_EN
    logic [7:0]   wb_count;
    logic         err_sticky;
`endif

    always #5 clk = ~clk;

    core2_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_rd_en  (res_rd_en),
        .res_data   (res_data),
        .res_empty  (res_empty),
        .op_rd_en   (op_rd_en),
        .op_data    (op_data),
        .op_empty   (op_empty),
        .w_D        (w_D),
        .adbus_D    (adbus_D),
        .data_out_D (data_out_D),
        .tmp_wr_en  (tmp_wr_en),
        .tmp_data   (tmp_data),
        .tmp_full   (tmp_full),
`ifdef CORE2_WB_STAT_EN
        .wb_count   (wb_count),
        .err_sticky (err_sticky),
`endif
        .bad_dest   (bad_dest),
        .busy       (busy)
    );

    // Upstream FIFO models with one-cycle read latency.
    logic [255:0] rmem [32];
    logic [15:0]  omem [32];
    logic [4:0]   rw = '0, rr = '0, ow = '0, orr = '0;
    logic         pop_r = 1'b0, pop_o = 1'b0;
    assign res_empty = rw == rr;
    assign op_empty  = ow == orr;

    always @(negedge clk) begin
        pop_r = res_rd_en;
        pop_o = op_rd_en;
    end
    always @(posedge clk) begin
        #1;
        if (pop_r) begin
            res_data = rmem[rr];
            rr = rr + 5'd1;
        end
        if (pop_o) begin
            op_data = omem[orr];
            orr = orr + 5'd1;
        end
    end

    typedef struct {int kind; logic [1:0] addr; logic [255:0] data;} exp_t;
    typedef struct {logic [2:0] dest; logic [1:0] addr; logic [255:0] data; int kind;} vec_t;
    exp_t sb [$];
    int total = 0, bad = 0;
    int cyc = 0, pop_cyc = 0, last_cyc = -1, commits = 0, exp_cnt = 0;
    bit lat_en = 1'b1, sp_en = 1'b0, exp_err = 1'b0;
    logic [1:0]   last_a = '0;
    logic [255:0] last_d = '0, last_t = '0;

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_rd_en || op_rd_en) begin
                chk("pop_pair", 256'({res_rd_en, op_rd_en}), 256'(2'b11));
                pop_cyc = cyc;
            end
            if (w_D || tmp_wr_en || bad_dest) begin
                int ak;
                exp_t e;
                commits++;
                ak = (int'(w_D) + int'(tmp_wr_en) + int'(bad_dest) > 1) ? 9 : w_D ? 0 : tmp_wr_en ? 1 : 2;
                if (sb.size() == 0) chk("unexpected_strobe", 256'(ak), 256'(99));
                else begin
                    e = sb.pop_front();
                    chk("kind", 256'(ak), 256'(e.kind));
                    if (e.kind == 0) begin
                        chk("adbus_D", 256'(adbus_D), 256'(e.addr));
                        chk("data_out_D", data_out_D, e.data);
                        last_a = e.addr;
                        last_d = e.data;
                        exp_cnt++;
                    end
                    if (e.kind == 1) begin
                        chk("tmp_data", tmp_data, e.data);
                        last_t = e.data;
                        exp_cnt++;
                    end
                    if (e.kind == 2) exp_err = 1'b1;
                    if (lat_en) chk("latency", 256'(cyc - pop_cyc), 256'(2));
                    if (sp_en && last_cyc >= 0) chk("spacing", 256'(cyc - last_cyc), 256'(3));
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic push(input logic [2:0] dest, input logic [1:0] a, input logic [255:0] d,
                        input bit rs, input bit os, input int kind);
        logic [15:0] op;
        @(posedge clk);
        #1;
        op = 16'($urandom);
        op[8:6] = dest;
        op[2:1] = a;
        if (rs) begin
            rmem[rw] = d;
            rw = rw + 5'd1;
        end
        if (os) begin
            omem[ow] = op;
            ow = ow + 5'd1;
        end
        if (kind >= 0) sb.push_back('{kind, a, d});
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = rr == rw && orr == ow && !busy && sb.size() == 0;
        end
        if (!done) chk("idle_timeout", 256'(0), 256'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pop();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = res_rd_en || op_rd_en;
        end
        if (!seen) chk("pop_timeout", 256'(0), 256'(1));
    endtask

    task automatic chk_stat();
`ifdef CORE2_WB_STAT_EN
        chk("wb_count", 256'(wb_count), 256'(exp_cnt));
        chk("err_sticky", 256'(err_sticky), 256'(exp_err));
`endif
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{DEST_D,    2'b10, {32{8'hA5}}, 0};
        tbl[1] = '{DEST_FIFO, 2'b00, 256'h1234, 1};
        tbl[2] = '{DEST_D,    2'b01, {8{32'hDEADBEEF}}, 0};
        tbl[3] = '{DEST_NONE, 2'b11, 256'h77, -1};
        tbl[4] = '{3'b001,    2'b00, 256'h55, 2};
        tbl[5] = '{3'b111,    2'b11, 256'h66, 2};
        tbl[6] = '{DEST_FIFO, 2'b11, {4{64'hCAFEF00D12345678}}, 1};

        #2;
        @(negedge clk);
        chk("rst_strobes", 256'({res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest, busy}), 256'(0));
        chk("rst_buses", {adbus_D, data_out_D[127:0], tmp_data[125:0]}, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_strobes", 256'({res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest, busy}), 256'(0));
        chk_stat();

        for (int i = 0; i < 7; i++) begin
            push(tbl[i].dest, tbl[i].addr, tbl[i].data, 1'b1, 1'b1, tbl[i].kind);
            wait_idle();
        end
        chk("hold_adbus", 256'(adbus_D), 256'(last_a));
        chk("hold_data_D", data_out_D, last_d);
        chk("hold_tmp", tmp_data, last_t);
        chk_stat();

        // tmp_full stall with a second entry waiting upstream
        lat_en = 1'b0;
        tmp_full = 1'b1;
        push(DEST_FIFO, 2'b00, 256'h1234, 1'b1, 1'b1, 1);
        wait_pop();
        push(DEST_D, 2'b11, 256'hBEEF, 1'b1, 1'b1, 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_wr", 256'(tmp_wr_en), 256'(0));
            chk("stall_pop", 256'({res_rd_en, op_rd_en}), 256'(0));
            chk("stall_busy", 256'(busy), 256'(1));
        end
        @(posedge clk);
        #1 tmp_full = 1'b0;
        wait_idle();
        lat_en = 1'b1;

        // pairing guard
        push(DEST_D, 2'b11, 256'h9999, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("guard_pop", 256'({res_rd_en, op_rd_en}), 256'(0));
        end
        push(DEST_D, 2'b11, 256'h0, 1'b0, 1'b1, -1);
        wait_pop();
        chk("pair_fire", 256'({res_rd_en, op_rd_en}), 256'(2'b11));
        wait_idle();
        chk_stat();

        // reset while in LATCH
        push(DEST_D, 2'b01, 256'hF00D, 1'b1, 1'b1, -1);
        wait_pop();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 256'({res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest, busy}), 256'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("post_rst_strobes", 256'({res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest, busy}), 256'(0));
        chk("post_rst_buses", {adbus_D, data_out_D[127:0], tmp_data[125:0]}, 256'(0));
        chk_stat();
        repeat (5) @(negedge clk);

        // back-to-back alternating destinations
        begin
            int c0;
            c0 = commits;
            sp_en = 1'b1;
            last_cyc = -1;
            push(DEST_D,    2'b00, 256'h11, 1'b1, 1'b1, 0);
            push(DEST_FIFO, 2'b01, 256'h22, 1'b1, 1'b1, 1);
            push(DEST_D,    2'b10, 256'h33, 1'b1, 1'b1, 0);
            push(DEST_FIFO, 2'b11, 256'h44, 1'b1, 1'b1, 1);
            wait_idle();
            sp_en = 1'b0;
            chk("b2b_commits", 256'(commits - c0), 256'(4));
`ifdef CORE2_WB_STAT_EN
            chk("b2b_wb_count", 256'(wb_count), 256'(4));
`endif
            chk_stat();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/core2_writeback.md
# core2_writeback

Drains the Core2 (multiplier) result path and commits each product to its destination. Each Core2 result is paired with the opcode held in the delayed-opcode FIFO, and the opcode's destination field is decoded. The result is then written to RAM D or pushed into the intermediate-result FIFO. The block is the reader-side counterpart of the sequencer, which issues multiplications and writes their opcodes into the delay FIFO; it owns the RAM D write port.

## Interface
- DATA, 256, result / RAM word width
- ADDR, 2, RAM D address width
- OPCODE_SIZE, 16, opcode width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- res_rd_en  out  ADDR-independent 1  pop Core2 output FIFO
- res_data  in  DATA  Core2 output FIFO data, valid cycle after pop
- res_empty  in  1  Core2 output FIFO empty (Out_Busy)
- op_rd_en  out  1  pop delayed-opcode FIFO
- op_data  in  OPCODE_SIZE  delayed opcode, valid cycle after pop
- op_empty  in  1  opcode FIFO empty (Out_Busy)
- w_D  out  1  RAM D write strobe
- adbus_D  out  ADDR  RAM D address
- data_out_D  out  DATA  RAM D write data
- tmp_wr_en  out  1  intermediate FIFO push
- tmp_data  out  DATA  intermediate FIFO data
- tmp_full  in  1  intermediate FIFO full (In_Busy)
- bad_dest  out  1  one-cycle pulse: result discarded on unsupported destination
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, LATCH, COMMIT.
- IDLE:
  - When !res_empty && !op_empty, assert res_rd_en and op_rd_en together for exactly one cycle, then go to LATCH.
  - Otherwise hold in IDLE with both pops low.
  - Never pop one FIFO without the other.
- LATCH:
  - Capture res_data into hold_data and op_data into hold_op.
  - Go to COMMIT.
- COMMIT decodes the destination field hold_op[8:6]:
  - 3'b100 (D): w_D=1, adbus_D=hold_op[2:1], data_out_D=hold_data for one cycle, then go to IDLE.
  - 3'b110 (FIFO) with !tmp_full: tmp_wr_en=1 and tmp_data=hold_data for one cycle, then go to IDLE.
  - 3'b110 (FIFO) with tmp_full: stall in COMMIT with tmp_wr_en=0, re-evaluating every cycle. The held result is never dropped.
  - 3'b000: discard silently and go to IDLE.
  - Any other code: discard, pulse bad_dest, and go to IDLE. Codes A/B/C/E and Ram_C belong to the sequencer, not this block.
- Data buses adbus_D, data_out_D and tmp_data hold their last value between writes.
- Reset values: state IDLE; res_rd_en, op_rd_en, w_D, tmp_wr_en, bad_dest and busy all 0; adbus_D, data_out_D, tmp_data, hold_data and hold_op all 0.
- Reset mid-operation discards any popped, uncommitted entry. The FIFOs have already advanced, so the sequencer must also be reset.

## Timing
- Upstream FIFOs have one-cycle registered read latency.
- Best-case latency is 3 cycles: pop at cycle N, latch at N+1, write strobe at N+2.
- Throughput is one result per 3 cycles. Each tmp_full stall cycle adds one cycle.
- Strobes (w_D, tmp_wr_en, bad_dest) are combinational from state and hold registers. They are single-cycle except where the tmp_full stall applies.
- A pop is issued only from IDLE, so at most one entry is ever in flight.
- An empty FIFO that becomes non-empty is sampled in the next IDLE cycle.

## Configuration
- CORE2_WB_STAT_EN defined:
  - Adds output wb_count[7:0], which increments on every w_D or tmp_wr_en and saturates at 8'hFF.
  - Adds output err_sticky, set by bad_dest and cleared only by rst_n.
  - Both reset to 0.
- CORE2_WB_STAT_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package core2_wb_pkg holds:
  - Destination codes DEST_NONE=3'b000, DEST_D=3'b100, DEST_FIFO=3'b110.
  - Field positions DEST_MSB=8, DEST_LSB=6, ADDR_MSB=2, ADDR_LSB=1.
  - The FSM state encoding.
- Sub-module core2_wb_stat implements the counter and sticky flag. It is instantiated only under CORE2_WB_STAT_EN.

## Test plan
- RAM D write:
  - Stimulus: push result 256'hA5..A5 and opcode with [8:6]=3'b100, [2:1]=2'b10.
  - Required: one pop pulse, then w_D=1 with adbus_D=2'b10 and data_out_D=A5..A5 exactly 2 cycles after the pop.
  - Required: tmp_wr_en stays 0.
- Temp FIFO push with stall:
  - Stimulus: push result 256'h1234 with destination 3'b110, hold tmp_full=1 for 4 cycles, then release.
  - Required: tmp_wr_en=0 throughout the stall, then a single pulse with tmp_data=256'h1234 in the cycle tmp_full drops.
  - Required: no second pop occurs during the stall.
- Pairing guard:
  - Stimulus: result FIFO non-empty while opcode FIFO is empty for 10 cycles.
  - Required: res_rd_en=0 and op_rd_en=0 for all 10 cycles.
  - Stimulus: opcode arrives.
  - Required: both pops fire in the same cycle.
- Bad destination:
  - Stimulus: destination 3'b001.
  - Required: bad_dest pulses once; w_D=0 and tmp_wr_en=0.
  - Required with CORE2_WB_STAT_EN: err_sticky=1 and wb_count unchanged.
- Back-to-back:
  - Stimulus: 4 queued results alternating D and FIFO destinations.
  - Required: 4 commits at 3-cycle spacing, in order, with wb_count=4.
- Reset mid-operation:
  - Stimulus: assert rst_n low during LATCH.
  - Required: all strobes drop immediately; after release, state is IDLE and outputs are 0.
